// File: rtl/led_frame_scheduler.sv
// LED strip frame scheduler: two round-robin 3-bit RGB writers fill a
// 24-bit-per-pixel buffer that is streamed to the serializer, followed by a latch gap.
module led_frame_scheduler #(
    parameter int NUM_LEDS     = 60,
    parameter int ADDR_W       = 6,
    parameter int LATCH_CYCLES = 600,
    parameter int LATCH_W      = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              refresh_en,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [2:0]        r_a,
    input  logic [2:0]        g_a,
    input  logic [2:0]        b_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [2:0]        r_b,
    input  logic [2:0]        g_b,
    input  logic [2:0]        b_b,
    output logic              gnt_b,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        LATCH  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   nxt_idx;
    logic [LATCH_W-1:0]  latch_cnt;
    logic                dirty;
    logic                last_b;
    logic [23:0]         pix_buf [NUM_LEDS];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [23:0]         wr_word;

    // 3-bit channel scaled so that 7 maps to 252
    function automatic logic [7:0] expand(input logic [2:0] c);
        return {5'd0, c} * 8'd36;
    endfunction

    // On contention the writer that was not granted last wins
    assign gnt_a   = req_a & (~req_b | last_b);
    assign gnt_b   = req_b & (~req_a | ~last_b);
    assign nxt_idx = idx + 1'b1;

    // Select the granted writer's word; out-of-range addresses never write
    always_comb begin
        wr_addr = addr_b;
        wr_word = {expand(b_b), expand(r_b), expand(g_b)};
        if (gnt_a) begin
            wr_addr = addr_a;
            wr_word = {expand(b_a), expand(r_a), expand(g_a)};
        end
        wr_en = (gnt_a | gnt_b) & (wr_addr <= LAST_IDX);
    end

    // Pixel buffer: one expanded word per LED, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                pix_buf[i] <= '0;
            end
        end else if (wr_en) begin
            pix_buf[wr_addr] <= wr_word;
        end
    end

    // Frame sequencer with registered stream outputs and dirty tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            latch_cnt  <= '0;
            dirty      <= 1'b0;
            last_b     <= 1'b0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (gnt_a | gnt_b) begin
                last_b <= gnt_b;
            end
            unique case (state)
                IDLE: begin
                    if (dirty | refresh_en) begin
                        state     <= STREAM;
                        idx       <= '0;
                        pix_data  <= pix_buf[0];
                        pix_valid <= 1'b1;
                        busy      <= 1'b1;
                        dirty     <= 1'b0;
                    end
                end
                STREAM: begin
                    if (pix_ready) begin
                        if (idx == LAST_IDX) begin
                            state     <= LATCH;
                            pix_valid <= 1'b0;
                            idx       <= '0;
                            latch_cnt <= '0;
                        end else begin
                            idx      <= nxt_idx;
                            pix_data <= pix_buf[nxt_idx];
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt == LATCH_LAST) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        latch_cnt  <= '0;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A write in the same cycle as frame entry keeps the buffer dirty
            if (wr_en) begin
                dirty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: scenario tasks driven against a
// pixel-array model of the buffer and frame timing.
`timescale 1ns/1ps
module tb_led_frame_scheduler;

    localparam int NUM = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        refresh_en = 1'b0;
    logic        req_a = 1'b0;
    logic [5:0]  addr_a = '0;
    logic [2:0]  r_a = '0, g_a = '0, b_a = '0;
    logic        gnt_a;
    logic        req_b = 1'b0;
    logic [5:0]  addr_b = '0;
    logic [2:0]  r_b = '0, g_b = '0, b_b = '0;
    logic        gnt_b;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [23:0] pix_data;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int first_cyc = 0;
    logic [23:0] mbuf [NUM];
    logic [23:0] rx [NUM];

    led_frame_scheduler dut (
        .clk(clk), .rst_n(rst_n), .refresh_en(refresh_en),
        .req_a(req_a), .addr_a(addr_a), .r_a(r_a), .g_a(g_a), .b_a(b_a),
        .gnt_a(gnt_a),
        .req_b(req_b), .addr_b(addr_b), .r_b(r_b), .g_b(g_b), .b_b(b_b),
        .gnt_b(gnt_b),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .busy(busy), .frame_done(frame_done)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] colour(input int r, input int g, input int b);
        return {8'(b * 36), 8'(r * 36), 8'(g * 36)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        pix_ready = 1'b0;
        refresh_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || pix_data !== 24'h0) begin
            fails++;
            $display("FAIL reset_outputs valid=%b busy=%b done=%b data=%h want all 0",
                     pix_valid, busy, frame_done, pix_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NUM; i++) mbuf[i] = 24'h0;
    endtask

    task automatic do_write(input bit wb, input int addr, input int r, input int g, input int b);
        if (wb) begin
            req_b = 1'b1; addr_b = 6'(addr); r_b = 3'(r); g_b = 3'(g); b_b = 3'(b);
        end else begin
            req_a = 1'b1; addr_a = 6'(addr); r_a = 3'(r); g_a = 3'(g); b_a = 3'(b);
        end
        #1;
        checks++;
        if (gnt_a !== !wb || gnt_b !== wb) begin
            fails++;
            $display("FAIL write_grant addr=%0d got a=%b b=%b want a=%b b=%b",
                     addr, gnt_a, gnt_b, !wb, wb);
        end
        @(posedge clk);
        if (addr < NUM) mbuf[addr] = colour(r, g, b);
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    // mode 0: ready held 1; mode 1: ready 1,0,0 repeating; mode 2: random ready
    task automatic collect_frame(input int mode, input int npix, input int wr_idx,
                                 input int wr_r, input int wr_g, input int wr_b);
        logic [23:0] snap [NUM];
        int got, t, ph;
        bit wrote, wnow, rdy;
        snap = mbuf;
        got = 0; t = 0; ph = 0; wrote = 0;
        while (pix_valid !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (pix_valid !== 1'b1) begin
            fails++;
            $display("FAIL frame_start valid=%b want 1 within %0d clks", pix_valid, t);
            return;
        end
        first_cyc = cyc;
        t = 0;
        while (got < npix && t < 5000) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (ph % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pix_ready = rdy;
            wnow = (wr_idx == got) && !wrote && !rdy;
            if (wnow) begin
                req_a = 1'b1; addr_a = 6'(wr_idx);
                r_a = 3'(wr_r); g_a = 3'(wr_g); b_a = 3'(wr_b);
            end
            #1;
            checks++;
            if (pix_valid !== 1'b1 || pix_data !== snap[got]) begin
                fails++;
                $display("FAIL pixel_%0d valid=%b data=%h want valid=1 data=%h",
                         got, pix_valid, pix_data, snap[got]);
            end
            if (wnow) begin
                checks++;
                if (gnt_a !== 1'b1) begin
                    fails++;
                    $display("FAIL stall_write_grant gnt_a=%b want 1", gnt_a);
                end
            end
            if (rdy && pix_valid === 1'b1) rx[got] = pix_data;
            @(posedge clk);
            if (wnow) begin
                mbuf[wr_idx] = colour(wr_r, wr_g, wr_b);
                wrote = 1'b1;
            end
            if (rdy && pix_valid === 1'b1) got++;
            @(negedge clk);
            req_a = 1'b0;
            ph++;
            t++;
        end
        pix_ready = 1'b0;
        checks++;
        if (got != npix) begin
            fails++;
            $display("FAIL frame_length got=%0d pixels want %0d", got, npix);
        end
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (pix_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_quiet active_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_single_write();
        int t;
        do_reset();
        do_write(1'b0, 5, 7, 0, 3);
        collect_frame(0, NUM, -1, 0, 0, 0);
        checks++;
        if (rx[5] !== 24'h6CFC00 || rx[4] !== 24'h0 || rx[59] !== 24'h0) begin
            fails++;
            $display("FAIL single_pixel px5=%h px4=%h px59=%h want 6cfc00 0 0",
                     rx[5], rx[4], rx[59]);
        end
        t = 0;
        while (frame_done !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (frame_done !== 1'b1 || cyc - first_cyc != 660) begin
            fails++;
            $display("FAIL frame_done_timing done=%b at=%0d want 1 at 660",
                     frame_done, cyc - first_cyc);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL frame_done_pulse done=%b busy=%b want 0 0", frame_done, busy);
        end
        t = 0;
        repeat (50) begin
            @(negedge clk);
            if (pix_valid !== 1'b0) t++;
        end
        checks++;
        if (t != 0) begin
            fails++;
            $display("FAIL no_second_frame valid_cycles=%0d want 0", t);
        end
    endtask

    task automatic test_contention();
        int ar, ag, ab, br, bg, bb;
        bit exp_b;
        do_reset();
        ar = $urandom_range(1, 7); ag = $urandom_range(0, 7); ab = $urandom_range(0, 7);
        br = $urandom_range(1, 7); bg = $urandom_range(0, 7); bb = $urandom_range(0, 7);
        req_a = 1'b1; addr_a = 6'd10; r_a = 3'(ar); g_a = 3'(ag); b_a = 3'(ab);
        req_b = 1'b1; addr_b = 6'd20; r_b = 3'(br); g_b = 3'(bg); b_b = 3'(bb);
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_b = (i % 2 == 0);
            checks++;
            if (gnt_a !== !exp_b || gnt_b !== exp_b) begin
                fails++;
                $display("FAIL contention_grant_%0d a=%b b=%b want a=%b b=%b",
                         i, gnt_a, gnt_b, !exp_b, exp_b);
            end
            @(posedge clk);
            if (exp_b) mbuf[20] = colour(br, bg, bb);
            else mbuf[10] = colour(ar, ag, ab);
            @(negedge clk);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        collect_frame(0, NUM, -1, 0, 0, 0);
        checks++;
        if (rx[10] !== colour(ar, ag, ab) || rx[20] !== colour(br, bg, bb)) begin
            fails++;
            $display("FAIL contention_words px10=%h px20=%h want %h %h",
                     rx[10], rx[20], colour(ar, ag, ab), colour(br, bg, bb));
        end
    endtask

    task automatic test_backpressure();
        int wr, wg, wb;
        do_reset();
        do_write(1'b0, 7, $urandom_range(0, 7), $urandom_range(0, 7), 5);
        wr = $urandom_range(1, 7); wg = $urandom_range(0, 7); wb = $urandom_range(0, 7);
        collect_frame(1, NUM, 3, wr, wg, wb);
        collect_frame(1, NUM, -1, 0, 0, 0);
        checks++;
        if (rx[3] !== colour(wr, wg, wb)) begin
            fails++;
            $display("FAIL held_write_next_frame px3=%h want %h", rx[3], colour(wr, wg, wb));
        end
    endtask

    task automatic test_random_writes();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            do_write(1'($urandom_range(0, 1)), $urandom_range(1, NUM - 1),
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        end
        collect_frame(2, NUM, -1, 0, 0, 0);
        collect_frame(2, NUM, -1, 0, 0, 0);
    endtask

    task automatic test_boundary();
        int bad, f1, r, g, b;
        do_reset();
        do_write(1'b0, 60, 7, 7, 7);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (pix_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL addr60_no_frame active_cycles=%0d want 0", bad);
        end
        r = $urandom_range(1, 7); g = $urandom_range(0, 7); b = $urandom_range(0, 7);
        do_write(1'b1, 59, r, g, b);
        collect_frame(0, NUM, -1, 0, 0, 0);
        checks++;
        if (rx[59] !== colour(r, g, b)) begin
            fails++;
            $display("FAIL last_pixel px59=%h want %h", rx[59], colour(r, g, b));
        end
        refresh_en = 1'b1;
        collect_frame(0, NUM, -1, 0, 0, 0);
        f1 = first_cyc;
        collect_frame(0, NUM, -1, 0, 0, 0);
        checks++;
        if (first_cyc - (f1 + NUM) != 601) begin
            fails++;
            $display("FAIL refresh_gap idle=%0d want 601", first_cyc - (f1 + NUM));
        end
        refresh_en = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        int r, g, b;
        do_reset();
        do_write(1'b0, 12, 7, 7, 7);
        collect_frame(0, 30, -1, 0, 0, 0);
        do_reset();
        r = $urandom_range(1, 7); g = $urandom_range(0, 7); b = $urandom_range(0, 7);
        do_write(1'b1, 40, r, g, b);
        collect_frame(0, NUM, -1, 0, 0, 0);
        checks++;
        if (rx[12] !== 24'h0 || rx[40] !== colour(r, g, b)) begin
            fails++;
            $display("FAIL post_reset_buffer px12=%h px40=%h want 0 %h",
                     rx[12], rx[40], colour(r, g, b));
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_backpressure();
        test_random_writes();
        test_boundary();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
